// File: rtl/window_pkg.sv
// Shared definitions for the KxK window filter: reduction mode encodings and width helpers.
package window_pkg;

    localparam logic [1:0] MODE_CENTRE = 2'b00;
    localparam logic [1:0] MODE_MAX    = 2'b01;
    localparam logic [1:0] MODE_MIN    = 2'b10;
    localparam logic [1:0] MODE_SUM    = 2'b11;

    // Ceiling log2, never below 1 so it can always size a vector.
    function automatic int clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    function automatic int col_width(input int img_w);
        return clog2(img_w);
    endfunction

    function automatic int sum_width(input int dw, input int k);
        return dw + clog2(k * k);
    endfunction

    // Widths for the default 640-wide, 8-bit, 5x5 configuration.
    localparam int COL_W = col_width(640);
    localparam int SUM_W = sum_width(8, 5);

endpackage

// File: rtl/window_filter_kxk_line_buffer.sv
// One raster line of delay: read-before-write RAM addressed by column, advancing on enable.
module line_buffer
    import window_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 640
) (
    input  logic                      clock,
    input  logic                      en,
    input  logic [clog2(DEPTH)-1:0]   addr,
    input  logic [DW-1:0]             wr_data,
    output logic [DW-1:0]             rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Asynchronous read returns the pixel from one line earlier before it is overwritten.
    assign rd_data = mem[addr];

    always_ff @(posedge clock) begin
        if (en) mem[addr] <= wr_data;
    end

endmodule

// File: rtl/window_filter_kxk.sv
// KxK causal window over a raster stream with run-time selectable reduction
// (centre, max, min, shifted saturating sum); fixed two-cycle latency.
module window_filter_kxk
    import window_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int K     = 5,
    parameter int SHIFT = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] din,
    input  logic          validin,
    input  logic          sof,
    input  logic          blanking_in,
    input  logic [1:0]    mode,
    output logic [DW-1:0] dout,
    output logic          validout,
    output logic          blanking_out,
    output logic          full_window
);

    localparam int H  = (K - 1) / 2;
    localparam int CW = col_width(IMG_W);
    localparam int RW = clog2(K);
    localparam int SW = sum_width(DW, K);

    logic [CW-1:0] col_q, cur_col, col_nx;
    logic [RW-1:0] row_q, cur_row, row_nx;
    logic [1:0]    mode_q, mode_cur;
    logic          pix_sof, col_wrap;

    logic [DW-1:0] lb_out  [K-1];
    logic [DW-1:0] col_tap [K];
    logic [DW-1:0] hist    [K][K-1];
    logic [DW-1:0] tap_raw [K][K];
    logic [DW-1:0] tap_c   [K][K];
    logic [DW-1:0] tap_q   [K][K];

    logic          valid_s1, blank_s1, full_s1, full_c;
    logic [1:0]    mode_s1;
    logic [DW-1:0] red;
    logic [DW-1:0] max_v, min_v;
    logic [SW-1:0] sum_v, sum_sh;

    assign pix_sof = validin & sof;

    // sof pixel is (0,0) and uses the freshly presented mode.
    always_comb begin
        cur_col  = pix_sof ? '0 : col_q;
        cur_row  = pix_sof ? '0 : row_q;
        mode_cur = pix_sof ? mode : mode_q;
        col_wrap = (cur_col == CW'(IMG_W - 1));
        col_nx   = col_wrap ? '0 : cur_col + CW'(1);
        row_nx   = (col_wrap && (cur_row != RW'(K - 1))) ? cur_row + RW'(1) : cur_row;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= MODE_CENTRE;
        end else if (validin) begin
            col_q  <= col_nx;
            row_q  <= row_nx;
            mode_q <= mode_cur;
        end
    end

    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        line_buffer #(
            .DW    (DW),
            .DEPTH (IMG_W)
        ) u_line_buffer (
            .clock   (clock),
            .en      (validin),
            .addr    (cur_col),
            .wr_data (col_tap[j]),
            .rd_data (lb_out[j])
        );
    end

    always_comb begin
        col_tap[0] = din;
        for (int j = 1; j < K; j++) col_tap[j] = lb_out[j-1];
    end

    // Tap column 0 is the live column; older columns come from the history shift registers.
    always_comb begin
        for (int dr = 0; dr < K; dr++) begin
            tap_raw[dr][0] = col_tap[dr];
            for (int dc = 1; dc < K; dc++) tap_raw[dr][dc] = hist[dr][dc-1];
        end
        for (int dr = 0; dr < K; dr++) begin
            for (int dc = 0; dc < K; dc++) begin
                tap_c[dr][dc] = ((cur_row < RW'(dr)) || (cur_col < CW'(dc))) ? '0 : tap_raw[dr][dc];
            end
        end
        full_c = (cur_row == RW'(K - 1)) && (cur_col >= CW'(K - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int dr = 0; dr < K; dr++) begin
                for (int dc = 0; dc < K - 1; dc++) hist[dr][dc] <= '0;
                for (int dc = 0; dc < K; dc++) tap_q[dr][dc] <= '0;
            end
            valid_s1 <= 1'b0;
            blank_s1 <= 1'b0;
            full_s1  <= 1'b0;
            mode_s1  <= MODE_CENTRE;
        end else begin
            valid_s1 <= validin;
            blank_s1 <= blanking_in;
            if (validin) begin
                for (int dr = 0; dr < K; dr++) begin
                    hist[dr][0] <= col_tap[dr];
                    for (int dc = 1; dc < K - 1; dc++) hist[dr][dc] <= hist[dr][dc-1];
                    for (int dc = 0; dc < K; dc++) tap_q[dr][dc] <= tap_c[dr][dc];
                end
                full_s1 <= full_c;
                mode_s1 <= mode_cur;
            end
        end
    end

    always_comb begin
        max_v = tap_q[0][0];
        min_v = tap_q[0][0];
        sum_v = '0;
        for (int dr = 0; dr < K; dr++) begin
            for (int dc = 0; dc < K; dc++) begin
                if (tap_q[dr][dc] > max_v) max_v = tap_q[dr][dc];
                if (tap_q[dr][dc] < min_v) min_v = tap_q[dr][dc];
                sum_v = sum_v + SW'(tap_q[dr][dc]);
            end
        end
        sum_sh = sum_v >> SHIFT;
        red    = '0;
        case (mode_s1)
            MODE_CENTRE: red = tap_q[H][H];
            MODE_MAX:    red = max_v;
            MODE_MIN:    red = min_v;
            default:     red = (sum_sh > SW'((1 << DW) - 1)) ? '1 : sum_sh[DW-1:0];
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dout         <= '0;
            validout     <= 1'b0;
            blanking_out <= 1'b0;
            full_window  <= 1'b0;
        end else begin
            validout     <= valid_s1;
            blanking_out <= blank_s1;
            if (valid_s1) begin
                dout        <= red;
                full_window <= full_s1;
            end
        end
    end

endmodule

// File: tb/tb_window_filter_kxk.sv
// Self-checking bench for window_filter_kxk (K=3, 4-pixel lines, SHIFT=3).
module tb_window_filter_kxk;
    import window_pkg::*;

    localparam int DW    = 8;
    localparam int IMG_W = 4;
    localparam int K     = 3;
    localparam int SHIFT = 3;
    localparam int NPIX  = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] din = '0;
    logic          validin = 1'b0;
    logic          sof = 1'b0;
    logic          blanking_in = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] dout;
    logic          validout, blanking_out, full_window;

    window_filter_kxk #(.DW(DW), .IMG_W(IMG_W), .K(K), .SHIFT(SHIFT)) dut (
        .clock        (clock),
        .reset        (reset),
        .din          (din),
        .validin      (validin),
        .sof          (sof),
        .blanking_in  (blanking_in),
        .mode         (mode),
        .dout         (dout),
        .validout     (validout),
        .blanking_out (blanking_out),
        .full_window  (full_window)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] md;
        int         pat;
        int         idx;
        int         exp_dout;
        bit         exp_full;
    } vec_t;

    int            n_chk = 0, n_fail = 0;
    int            rst_err = 0, blank_err = 0;
    logic [1:0]    bq;
    logic [DW-1:0] act_d [$];
    logic          act_f [$];
    int            img [4][4];
    int            exp_d [NPIX];
    bit            exp_f [NPIX];
    int            got_d [NPIX];
    int            got_f [NPIX];
    int            keep_d [NPIX];
    int            keep_f [NPIX];
    vec_t          vecs [20];

    // blanking_in as seen two clock edges ago
    always @(posedge clock or negedge reset) begin
        if (!reset) bq <= 2'b00;
        else        bq <= {bq[0], blanking_in};
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (dout != '0 || validout || blanking_out || full_window) rst_err++;
        end else begin
            if (blanking_out !== bq[1]) blank_err++;
            if (validout) begin
                act_d.push_back(dout);
                act_f.push_back(full_window);
            end
        end
    end

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int pat_val(input int pat, input int r, input int c);
        case (pat)
            0:       return r * IMG_W + c + 1;
            1:       return (r == 1 && c == 1) ? 200 : 10;
            2:       return 8;
            3:       return 255;
            4:       return 50;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Reference: window of pixels up/left of (r,c) in the current frame, zero outside the image.
    function automatic int ref_pix(input logic [1:0] md, input int r, input int c);
        int t, mx, mn, sm;
        mx = 0; mn = 256; sm = 0;
        for (int dr = 0; dr < K; dr++) begin
            for (int dc = 0; dc < K; dc++) begin
                t = (r >= dr && c >= dc) ? img[r-dr][c-dc] : 0;
                if (t > mx) mx = t;
                if (t < mn) mn = t;
                sm += t;
            end
        end
        case (md)
            MODE_CENTRE: return (r >= 1 && c >= 1) ? img[r-1][c-1] : 0;
            MODE_MAX:    return mx;
            MODE_MIN:    return mn;
            default:     return ((sm >> SHIFT) > 255) ? 255 : (sm >> SHIFT);
        endcase
    endfunction

    task automatic drive_pix(input int d, input bit s, input logic [1:0] md, input bit b);
        @(posedge clock);
        #1;
        din = DW'(d); validin = 1'b1; sof = s; mode = md; blanking_in = b;
    endtask

    // Idle cycles carry garbage data, stray sof and mode changes that must all be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            validin = 1'b0; din = DW'($urandom); sof = 1'($urandom);
            mode = 2'($urandom); blanking_in = 1'($urandom);
        end
    endtask

    task automatic run_frame(input int pat, input logic [1:0] md, input bit gaps, input string tag);
        int base, r, c, v, n;
        base = act_d.size();
        for (int i = 0; i < NPIX; i++) begin
            r = i / IMG_W; c = i % IMG_W;
            v = pat_val(pat, r, c);
            img[r][c] = v;
            exp_d[i] = ref_pix(md, r, c);
            exp_f[i] = (r >= K - 1) && (c >= K - 1);
            drive_pix(v, i == 0, (i == 0) ? md : 2'($urandom), 1'($urandom));
            if (gaps) idle(int'($urandom_range(0, 3)));
        end
        idle(1);
        n = 0;
        while ((act_d.size() - base) < NPIX && n < 20) begin
            idle(1);
            n++;
        end
        idle(3);
        check({tag, " output count"}, act_d.size() - base, NPIX);
        for (int i = 0; i < NPIX; i++) begin
            if (base + i < act_d.size()) begin
                got_d[i] = int'(act_d[base+i]);
                got_f[i] = int'(act_f[base+i]);
            end else begin
                got_d[i] = -1;
                got_f[i] = -1;
            end
            check($sformatf("%s dout[%0d]", tag, i), got_d[i], exp_d[i]);
            check($sformatf("%s full_window[%0d]", tag, i), got_f[i], int'(exp_f[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        logic [1:0] rmd;

        vecs[0]  = '{MODE_CENTRE, 0, 10,   6, 1'b1};
        vecs[1]  = '{MODE_CENTRE, 0,  0,   0, 1'b0};
        vecs[2]  = '{MODE_CENTRE, 0,  4,   0, 1'b0};
        vecs[3]  = '{MODE_CENTRE, 0,  2,   0, 1'b0};
        vecs[4]  = '{MODE_CENTRE, 0,  5,   1, 1'b0};
        vecs[5]  = '{MODE_CENTRE, 0, 15,  11, 1'b1};
        vecs[6]  = '{MODE_MAX,    1,  5, 200, 1'b0};
        vecs[7]  = '{MODE_MAX,    1, 15, 200, 1'b1};
        vecs[8]  = '{MODE_MAX,    1, 13, 200, 1'b0};
        vecs[9]  = '{MODE_MAX,    1,  0,  10, 1'b0};
        vecs[10] = '{MODE_MAX,    1,  4,  10, 1'b0};
        vecs[11] = '{MODE_MAX,    1, 12,  10, 1'b0};
        vecs[12] = '{MODE_SUM,    2, 10,   9, 1'b1};
        vecs[13] = '{MODE_SUM,    2,  0,   1, 1'b0};
        vecs[14] = '{MODE_SUM,    3, 15, 255, 1'b1};
        vecs[15] = '{MODE_SUM,    3,  0,  31, 1'b0};
        vecs[16] = '{MODE_MIN,    4, 10,  50, 1'b1};
        vecs[17] = '{MODE_MIN,    4,  2,   0, 1'b0};
        vecs[18] = '{MODE_MIN,    4,  0,   0, 1'b0};
        vecs[19] = '{MODE_MIN,    1, 15,  10, 1'b1};

        // Held in reset with validin toggling: outputs must stay zero.
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            validin = ~validin; din = DW'($urandom); sof = 1'($urandom);
        end
        validin = 1'b0; sof = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("post-reset dout", int'(dout), 0);
        check("post-reset validout", int'(validout), 0);
        check("post-reset blanking_out", int'(blanking_out), 0);
        check("post-reset full_window", int'(full_window), 0);
        check("post-reset outputs seen", act_d.size(), 0);

        for (int v = 0; v < 20; v++) begin
            run_frame(vecs[v].pat, vecs[v].md, 1'b0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d probe dout", v), got_d[vecs[v].idx], vecs[v].exp_dout);
            check($sformatf("vec%0d probe full", v), got_f[vecs[v].idx], int'(vecs[v].exp_full));
        end

        // Gapped stream must reproduce the gap-free sequence.
        run_frame(0, MODE_CENTRE, 1'b0, "nogap");
        for (int i = 0; i < NPIX; i++) begin
            keep_d[i] = got_d[i];
            keep_f[i] = got_f[i];
        end
        run_frame(0, MODE_CENTRE, 1'b1, "gap");
        for (int i = 0; i < NPIX; i++) begin
            check($sformatf("gap vs nogap dout[%0d]", i), got_d[i], keep_d[i]);
            check($sformatf("gap vs nogap full[%0d]", i), got_f[i], keep_f[i]);
        end

        // Abandoned partial frame followed by a new sof without reset.
        for (int i = 0; i < 6; i++) drive_pix(int'($urandom_range(0, 255)), i == 0, MODE_MAX, 1'b0);
        idle(3);
        rmd = 2'($urandom);
        run_frame(5, rmd, 1'b1, "restart");

        for (int f = 0; f < 4; f++) begin
            rmd = 2'($urandom);
            run_frame(5, rmd, 1'($urandom), $sformatf("rand%0d", f));
        end

        // Reset in the middle of a frame, then a clean all-50 frame in min mode.
        for (int i = 0; i < 7; i++) drive_pix(200, i == 0, MODE_MAX, 1'b0);
        reset = 1'b0;
        validin = 1'b0;
        s0 = act_d.size();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        idle(3);
        check("no output after mid-frame reset", act_d.size(), s0);
        run_frame(4, MODE_MIN, 1'b0, "midrst");

        check("outputs nonzero during reset", rst_err, 0);
        check("blanking_out delay errors", blank_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
